// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: captures an 8-bit word and steps a 3-bit select through
// its bit indices so a downstream mux_8_to_1 serialises it, DIV cycles per bit.
module mux_sel_sequencer #(
    parameter int unsigned DIV       = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       stall_i,
    output logic [7:0] d_o,
    output logic [2:0] sel_o,
    output logic       bit_valid_o,
    output logic       last_o,
    output logic       busy_o
);

    localparam int unsigned    CNT_W     = 4;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]     FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0]     LAST_BIT  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic             in_shift;
    logic             beat_done;
    logic             word_end;
    logic             accept;

    // Beat and handshake decode; reset forces all status low immediately
    assign in_shift    = (state == SHIFT) && !rst_i;
    assign beat_done   = in_shift && !stall_i && (div_cnt == DIV_LAST);
    assign word_end    = beat_done && (bit_cnt == LAST_BIT);
    assign ready_o     = !rst_i && ((state == IDLE) || word_end);
    assign accept      = valid_i && ready_o;
    assign bit_valid_o = in_shift;
    assign busy_o      = in_shift;
    assign last_o      = in_shift && (bit_cnt == LAST_BIT);

    // Sequencer state, captured word and bit/divider counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            d_o     <= 8'h00;
            sel_o   <= 3'd0;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_o     <= data_i;
                        sel_o   <= FIRST_SEL;
                        div_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!stall_i) begin
                        if (beat_done) begin
                            div_cnt <= '0;
                            if (bit_cnt != LAST_BIT) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sel_o   <= MSB_FIRST ? (sel_o - 3'd1) : (sel_o + 3'd1);
                            end else if (accept) begin
                                // Back-to-back word: reload without an idle gap
                                d_o     <= data_i;
                                sel_o   <= FIRST_SEL;
                                bit_cnt <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            div_cnt <= div_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: three parameterisations share stimulus.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       stall;
    logic [7:0] data;

    logic       a_ready, a_bv, a_last, a_busy;
    logic [7:0] a_d;
    logic [2:0] a_sel;
    logic       b_ready, b_bv, b_last, b_busy;
    logic [7:0] b_d;
    logic [2:0] b_sel;
    logic       c_ready, c_bv, c_last, c_busy;
    logic [7:0] c_d;
    logic [2:0] c_sel;

    int total;
    int bad;

    mux_sel_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(a_ready),
        .stall_i(stall), .d_o(a_d), .sel_o(a_sel), .bit_valid_o(a_bv),
        .last_o(a_last), .busy_o(a_busy)
    );
    mux_sel_sequencer #(.DIV(1), .MSB_FIRST(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(b_ready),
        .stall_i(stall), .d_o(b_d), .sel_o(b_sel), .bit_valid_o(b_bv),
        .last_o(b_last), .busy_o(b_busy)
    );
    mux_sel_sequencer #(.DIV(3), .MSB_FIRST(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(c_ready),
        .stall_i(stall), .d_o(c_d), .sel_o(c_sel), .bit_valid_o(c_bv),
        .last_o(c_last), .busy_o(c_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       stall;
        logic [7:0] data;
        logic       ready;
        logic       bv;
        logic       last;
        logic       busy;
        logic [2:0] sel;
        logic [7:0] d;
        logic       y;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs at the falling edge, let outputs settle before checks
    task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] dat);
        @(negedge clk);
        rst   = r;
        valid = v;
        stall = s;
        data  = dat;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic yv;
        logic [7:0] y_msb;
        clk   = 1'b0;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        valid = 1'b0;
        stall = 1'b0;
        data  = 8'h00;

        // rows: rst valid stall data | ready bv last busy sel d y
        vecs[0] = {1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[1] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b0};
        vecs[2] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'hAA, 1'b1};
        vecs[3] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'hAA, 1'b0};
        vecs[4] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'hAA, 1'b1};
        vecs[5] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'hAA, 1'b0};
        vecs[6] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'hAA, 1'b1};
        vecs[7] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'hAA, 1'b0};
        vecs[8] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'hAA, 1'b1};
        vecs[9] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'hAA, 1'b1};

        // Reset behaviour, including a valid presented during reset
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        chk("rst_ready", a_ready, 0);
        chk("rst_bv", a_bv, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_last", a_last, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_rst_d", a_d, 8'h00);
        chk("post_rst_sel", a_sel, 0);
        chk("post_rst_ready", a_ready, 1);
        chk("post_rst_busy", a_busy, 0);

        // Basic LSB-first word, cycle by cycle
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].stall, vecs[i].data);
            chk($sformatf("tbl%0d_ready", i), a_ready, vecs[i].ready);
            chk($sformatf("tbl%0d_bv", i), a_bv, vecs[i].bv);
            chk($sformatf("tbl%0d_last", i), a_last, vecs[i].last);
            chk($sformatf("tbl%0d_busy", i), a_busy, vecs[i].busy);
            chk($sformatf("tbl%0d_sel", i), a_sel, vecs[i].sel);
            chk($sformatf("tbl%0d_d", i), a_d, vecs[i].d);
            yv = a_d[a_sel];
            chk($sformatf("tbl%0d_y", i), yv, vecs[i].y);
        end

        // MSB-first word 8'hC3
        y_msb = 8'b11000011;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'hC3);
        chk("msb_ready_idle", b_ready, 1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("msb%0d_sel", k), b_sel, 7 - k);
            yv = b_d[b_sel];
            chk($sformatf("msb%0d_y", k), yv, y_msb[7 - k]);
            chk($sformatf("msb%0d_last", k), b_last, (k == 7) ? 1 : 0);
            chk($sformatf("msb%0d_bv", k), b_bv, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("msb_idle_bv", b_bv, 0);

        // DIV=3: each index held 3 cycles, 24 valid cycles
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'hFF);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            if (!c_bv) break;
            if (n < 24) chk($sformatf("div3_%0d_sel", n), c_sel, n / 3);
            cnt++;
        end
        chk("div3_len", cnt, 24);

        // Back-to-back words with valid held high
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, (k <= 8) ? 1'b1 : 1'b0, 1'b0, 8'hAA);
            chk($sformatf("b2b%0d_ready", k), a_ready, (k == 8 || k == 16) ? 1 : 0);
            chk($sformatf("b2b%0d_bv", k), a_bv, 1);
            chk($sformatf("b2b%0d_sel", k), a_sel, (k - 1) % 8);
            chk($sformatf("b2b%0d_d", k), a_d, (k <= 8) ? 8'h55 : 8'hAA);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("b2b_end_bv", a_bv, 0);

        // Stall for 4 cycles at sel=3, plus an ignored valid mid-word
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        chk("ign_ready", a_ready, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ign_d", a_d, 8'h5A);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h11);
            chk($sformatf("stall%0d_sel", k), a_sel, 3);
            chk($sformatf("stall%0d_ready", k), a_ready, 0);
            chk($sformatf("stall%0d_bv", k), a_bv, 1);
        end
        cnt = 7;
        for (int n = 0; n < 20; n++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            if (!a_bv) break;
            cnt++;
        end
        chk("stall_len", cnt, 12);
        chk("stall_d", a_d, 8'h5A);

        // Stall has no effect while idle
        drive(1'b0, 1'b1, 1'b1, 8'hE7);
        chk("idle_stall_ready", a_ready, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_stall_busy", a_busy, 1);
        chk("idle_stall_d", a_d, 8'hE7);

        // Reset pulse mid-word at sel=5 with a simultaneous valid
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h96);
        for (int k = 1; k <= 5; k++) drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hFF);
        chk("mrst_sel_before", a_sel, 5);
        chk("mrst_ready", a_ready, 0);
        chk("mrst_bv", a_bv, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_after_bv", a_bv, 0);
        chk("mrst_after_sel", a_sel, 0);
        chk("mrst_after_d", a_d, 8'h00);
        chk("mrst_after_ready", a_ready, 1);
        chk("mrst_after_busy", a_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 Parameter: DIV, default 1, number of un-stalled clock cycles each bit index is held (legal 1..16).
REQ-002 Parameter: MSB_FIRST, default 0, 0 = index order 0→7, 1 = index order 7→0.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port: data_i  input  8  word to be presented to the downstream mux_8_to_1.
REQ-006 Port: valid_i  input  1  data_i is valid.
REQ-007 Port: ready_o  output  1  block accepts data_i this cycle.
REQ-008 Port: stall_i  input  1  freezes bit advance while high.
REQ-009 Port: d_o  output  8  captured word; drives mux_8_to_1 d_i.
REQ-010 Port: sel_o  output  3  current bit index; drives mux_8_to_1 sel_i.
REQ-011 Port: bit_valid_o  output  1  d_o/sel_o present a valid bit this cycle.
REQ-012 Port: last_o  output  1  current bit is the 8th of the word.
REQ-013 Port: busy_o  output  1  word in progress (state SHIFT).

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-015 Accept = valid_i && ready_o, sampled at a rising edge.
REQ-016 In IDLE, ready_o SHALL be 1; bit_valid_o, last_o and busy_o SHALL be 0; d_o and sel_o hold their last values.
REQ-017 On accept in IDLE: d_o ← data_i, sel_o ← first index (0, or 7 if MSB_FIRST), bit_cnt ← 0, div_cnt ← 0, state → SHIFT; first bit is valid the next cycle (latency 1).
REQ-018 In SHIFT: bit_valid_o = 1, busy_o = 1, d_o SHALL be constant for the whole word.
REQ-019 beat_done = SHIFT && !stall_i && div_cnt == DIV-1.
REQ-020 div_cnt SHALL increment on each SHIFT cycle with stall_i=0, and clear to 0 on beat_done.
REQ-021 On beat_done with bit_cnt < 7: bit_cnt +1, sel_o +1 (MSB_FIRST=0) or −1 (MSB_FIRST=1).
REQ-022 last_o = SHIFT && bit_cnt == 7, independent of sel_o value or MSB_FIRST.
REQ-023 ready_o in SHIFT = beat_done && bit_cnt == 7 (back-to-back accept on final beat only).
REQ-024 On beat_done with bit_cnt == 7: if accept, reload per REQ-017 and stay in SHIFT (no idle gap); else → IDLE.
REQ-025 stall_i high: div_cnt, bit_cnt, sel_o, state frozen; bit_valid_o stays 1; ready_o = 0.
REQ-026 stall_i has no effect in IDLE.
REQ-027 valid_i while ready_o = 0 SHALL be ignored; data_i is not latched.
REQ-028 Un-stalled word duration SHALL be exactly 8*DIV cycles.

Reset
REQ-029 While rst_i = 1 at a rising edge: state → IDLE, d_o = 8'h00, sel_o = 3'd0, div_cnt = 0, bit_cnt = 0.
REQ-030 While rst_i is high, ready_o SHALL be 0; bit_valid_o, last_o, busy_o SHALL be 0.
REQ-031 Reset mid-word SHALL abort the word with no further bit_valid_o; a valid_i presented in the same cycle as reset SHALL be dropped.

Verification
REQ-032 DIV=1, MSB_FIRST=0, accept 8'b10101010 at cycle 0 -> cycles 1..8 sel_o = 0..7, downstream mux y = 0,1,0,1,0,1,0,1; last_o only at cycle 8; IDLE at cycle 9.
REQ-033 MSB_FIRST=1, accept 8'hC3 -> sel_o = 7..0, mux y = 1,1,0,0,0,0,1,1; last_o with sel_o = 0.
REQ-034 DIV=3, accept 8'hFF -> each sel_o held 3 cycles, bit_valid_o high for 24 cycles.
REQ-035 DIV=1, valid_i held high with 8'h55 then 8'hAA -> ready_o high at cycle 8, second word starts cycle 9, 16 contiguous bit_valid_o cycles.
REQ-036 stall_i high 4 cycles while sel_o = 3 -> sel_o stays 3, ready_o = 0, total word length 12 cycles.
REQ-037 rst_i pulsed 1 cycle while sel_o = 5 -> next cycle: bit_valid_o = 0, sel_o = 0, d_o = 8'h00, ready_o = 1 after release.
